// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants, types and helpers for the write arbiter slice.
package regfile_pkg;

    localparam int REG_ADDR_W   = 3;
    localparam int DATA_W       = 8;
    localparam int NUM_REGS     = 8;
    localparam int STARVE_CNT_W = 4;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     reg_data_t;

    localparam reg_addr_t ZERO_REG = 3'd0;

    // Which requester owns the write port this cycle.
    typedef enum logic [1:0] {
        GRANT_NONE,
        GRANT_WB,
        GRANT_MC
    } grant_e;

    // True when the address is the hardwired-zero register and protection is on.
    function automatic logic isProtected(input reg_addr_t addr, input logic zeroProtect);
        return zeroProtect && (addr == ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bundle of the WB, MC, issue, decode and register-file write-port signals.
// The master side is the pipeline/multicycle unit, the slave side is the arbiter.
interface regfile_write_arbiter_if;
    import regfile_pkg::*;

    logic      wb_valid;
    reg_addr_t wb_reg;
    reg_data_t wb_data;
    logic      wb_stall;

    logic      mc_valid;
    reg_addr_t mc_reg;
    reg_data_t mc_data;
    logic      mc_ready;

    logic      issue_valid;
    reg_addr_t issue_reg;
    logic      issue_ready;

    reg_addr_t ReadReg1;
    reg_addr_t ReadReg2;
    logic      hazard1;
    logic      hazard2;
    logic [NUM_REGS-1:0] busy;

    logic      RegWrite;
    reg_addr_t WriteReg;
    reg_data_t WriteData;

    modport master (
        output wb_valid, wb_reg, wb_data,
        output mc_valid, mc_reg, mc_data,
        output issue_valid, issue_reg,
        output ReadReg1, ReadReg2,
        input  wb_stall, mc_ready, issue_ready,
        input  hazard1, hazard2, busy,
        input  RegWrite, WriteReg, WriteData
    );

    modport slave (
        input  wb_valid, wb_reg, wb_data,
        input  mc_valid, mc_reg, mc_data,
        input  issue_valid, issue_reg,
        input  ReadReg1, ReadReg2,
        output wb_stall, mc_ready, issue_ready,
        output hazard1, hazard2, busy,
        output RegWrite, WriteReg, WriteData
    );

endinterface

// File: rtl/regfile_write_arbiter_scoreboard.sv
// Busy scoreboard: one bit per register with an MC result still outstanding.
// Drives issue back-pressure and decode hazards.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter logic ZERO_PROTECT = 1'b1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                issue_valid_i,
    input  reg_addr_t           issue_reg_i,
    input  logic                mc_grant_i,
    input  reg_addr_t           mc_reg_i,
    input  reg_addr_t           read_reg1_i,
    input  reg_addr_t           read_reg2_i,
    output logic                issue_ready_o,
    output logic                hazard1_o,
    output logic                hazard2_o,
    output logic [NUM_REGS-1:0] busy_o
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0] setMask;
    logic [NUM_REGS-1:0] clrMask;

    assign issue_ready_o = !busy_q[issue_reg_i];
    assign busy_o        = busy_q;

    // A grant releases the hazard one cycle early: the write lands on the negedge before the next read.
    assign hazard1_o = busy_q[read_reg1_i] && !(mc_grant_i && (mc_reg_i == read_reg1_i));
    assign hazard2_o = busy_q[read_reg2_i] && !(mc_grant_i && (mc_reg_i == read_reg2_i));

    // Next busy vector: clear on MC completion, then set on accepted issue so a same-register set wins.
    always_comb begin
        setMask = '0;
        clrMask = '0;
        if (issue_valid_i && issue_ready_o && !isProtected(issue_reg_i, ZERO_PROTECT)) begin
            setMask[issue_reg_i] = 1'b1;
        end
        if (mc_grant_i) begin
            clrMask[mc_reg_i] = 1'b1;
        end
        busy_d = (busy_q & ~clrMask) | setMask;
    end

    // Busy vector register; reset drops every reservation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between WB (priority) and the multicycle unit,
// with a starvation guard that stalls WB for one cycle after MC loses STARVE_LIMIT times.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int   STARVE_LIMIT = 4,
    parameter logic ZERO_PROTECT = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    regfile_write_arbiter_if.slave  bus
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_MAX = STARVE_CNT_W'(STARVE_LIMIT);

    grant_e                  grant;
    logic                    starving;
    logic                    mcGrant;
    logic [STARVE_CNT_W-1:0] starveCnt_q;
    logic [STARVE_CNT_W-1:0] starveCnt_d;
    logic                    regWrite_q;
    logic                    regWrite_d;
    reg_addr_t               writeReg_q;
    reg_addr_t               writeReg_d;
    reg_data_t               writeData_q;
    reg_data_t               writeData_d;

    // Pick the owner of the write port: WB unless MC has been starved long enough.
    always_comb begin
        starving = bus.mc_valid && (starveCnt_q == STARVE_MAX);
        grant    = GRANT_NONE;
        if (bus.wb_valid && !starving) begin
            grant = GRANT_WB;
        end else if (bus.mc_valid) begin
            grant = GRANT_MC;
        end
    end

    assign mcGrant      = (grant == GRANT_MC);
    assign bus.wb_stall = bus.wb_valid && starving;
    assign bus.mc_ready = mcGrant;

    // Count consecutive MC losses, saturating at the limit; any MC win or idle cycle restarts it.
    always_comb begin
        starveCnt_d = starveCnt_q;
        if (!bus.mc_valid || mcGrant) begin
            starveCnt_d = '0;
        end else if (starveCnt_q < STARVE_MAX) begin
            starveCnt_d = starveCnt_q + 1'b1;
        end
    end

    // Capture the winner's address/data; write enable is suppressed for protected register 0.
    always_comb begin
        regWrite_d  = 1'b0;
        writeReg_d  = writeReg_q;
        writeData_d = writeData_q;
        unique case (grant)
            GRANT_WB: begin
                regWrite_d  = !isProtected(bus.wb_reg, ZERO_PROTECT);
                writeReg_d  = bus.wb_reg;
                writeData_d = bus.wb_data;
            end
            GRANT_MC: begin
                regWrite_d  = !isProtected(bus.mc_reg, ZERO_PROTECT);
                writeReg_d  = bus.mc_reg;
                writeData_d = bus.mc_data;
            end
            default: begin
                regWrite_d = 1'b0;
            end
        endcase
    end

    // Starvation counter and registered write port; stable well before the register file's negedge write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starveCnt_q <= '0;
            regWrite_q  <= 1'b0;
            writeReg_q  <= '0;
            writeData_q <= '0;
        end else begin
            starveCnt_q <= starveCnt_d;
            regWrite_q  <= regWrite_d;
            writeReg_q  <= writeReg_d;
            writeData_q <= writeData_d;
        end
    end

    assign bus.RegWrite  = regWrite_q;
    assign bus.WriteReg  = writeReg_q;
    assign bus.WriteData = writeData_q;

    regfile_scoreboard #(
        .ZERO_PROTECT (ZERO_PROTECT)
    ) u_scoreboard (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_valid_i (bus.issue_valid),
        .issue_reg_i   (bus.issue_reg),
        .mc_grant_i    (mcGrant),
        .mc_reg_i      (bus.mc_reg),
        .read_reg1_i   (bus.ReadReg1),
        .read_reg2_i   (bus.ReadReg2),
        .issue_ready_o (bus.issue_ready),
        .hazard1_o     (bus.hazard1),
        .hazard2_o     (bus.hazard2),
        .busy_o        (bus.busy)
    );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for the register-file write arbiter: vector table for per-cycle behaviour,
// a queue of expected write-port results, and a hand-written async-reset sequence.
module tb_regfile_write_arbiter;
    import regfile_pkg::*;

    typedef struct {
        logic       wbV;
        logic [2:0] wbReg;
        logic [7:0] wbData;
        logic       mcV;
        logic [2:0] mcReg;
        logic [7:0] mcData;
        logic       isV;
        logic [2:0] isReg;
        logic [2:0] rr1;
        logic [2:0] rr2;
        logic       xStall;
        logic       xMcReady;
        logic       xIssueReady;
        logic       xHaz1;
        logic       xHaz2;
        logic       xRegWrite;
        logic [2:0] xWReg;
        logic [7:0] xWData;
        logic [7:0] xBusy;
    } vec_t;

    typedef struct {
        logic       rw;
        logic [2:0] wreg;
        logic [7:0] wdata;
        logic [7:0] busy;
        int         idx;
    } exp_t;

    localparam int NVEC = 22;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs [NVEC];
    exp_t expQ [$];
    logic [7:0] rf [8];

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(
        .STARVE_LIMIT (4),
        .ZERO_PROTECT (1'b1)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Register file model: written on the falling edge from the registered write port.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
        end else if (bus.RegWrite) begin
            rf[bus.WriteReg] <= bus.WriteData;
        end
    end

    // Global watchdog so the run always ends.
    initial begin
        #100000;
        $display("[TB] FAIL timeout: got no finish expected finish before 100000");
        $fatal(1, "[TB] timeout");
    end

    task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        bus.wb_valid = 0; bus.wb_reg = 0; bus.wb_data = 0;
        bus.mc_valid = 0; bus.mc_reg = 0; bus.mc_data = 0;
        bus.issue_valid = 0; bus.issue_reg = 0;
        bus.ReadReg1 = 0; bus.ReadReg2 = 0;
    endtask

    // Drive one vector mid-cycle, check the combinational outputs, queue the expected write.
    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        #1;
        bus.wb_valid = v.wbV; bus.wb_reg = v.wbReg; bus.wb_data = v.wbData;
        bus.mc_valid = v.mcV; bus.mc_reg = v.mcReg; bus.mc_data = v.mcData;
        bus.issue_valid = v.isV; bus.issue_reg = v.isReg;
        bus.ReadReg1 = v.rr1; bus.ReadReg2 = v.rr2;
        #1;
        checkVal($sformatf("row%0d wb_stall", idx), {7'b0, bus.wb_stall}, {7'b0, v.xStall});
        checkVal($sformatf("row%0d mc_ready", idx), {7'b0, bus.mc_ready}, {7'b0, v.xMcReady});
        checkVal($sformatf("row%0d issue_ready", idx), {7'b0, bus.issue_ready}, {7'b0, v.xIssueReady});
        checkVal($sformatf("row%0d hazard1", idx), {7'b0, bus.hazard1}, {7'b0, v.xHaz1});
        checkVal($sformatf("row%0d hazard2", idx), {7'b0, bus.hazard2}, {7'b0, v.xHaz2});
        e.rw = v.xRegWrite; e.wreg = v.xWReg; e.wdata = v.xWData; e.busy = v.xBusy; e.idx = idx;
        expQ.push_back(e);
    endtask

    // After the next posedge, pop the expected write-port state and compare.
    task automatic checkOutput();
        exp_t e;
        @(posedge clk);
        #1;
        checks++;
        if (expQ.size() == 0) begin
            errors++;
            $display("[TB] FAIL queue: got empty expected an entry");
        end else begin
            e = expQ.pop_front();
            checkVal($sformatf("row%0d RegWrite", e.idx), {7'b0, bus.RegWrite}, {7'b0, e.rw});
            if (e.rw) begin
                checkVal($sformatf("row%0d WriteReg", e.idx), {5'b0, bus.WriteReg}, {5'b0, e.wreg});
                checkVal($sformatf("row%0d WriteData", e.idx), bus.WriteData, e.wdata);
            end
            checkVal($sformatf("row%0d busy", e.idx), bus.busy, e.busy);
        end
    endtask

    initial begin
        // wbV wbReg wbData mcV mcReg mcData isV isReg rr1 rr2 | stall mcR isR h1 h2 | rw wreg wdata busy
        vecs[0]  = '{0,0,8'h00, 0,0,8'h00, 0,0, 0,0, 0,0,1,0,0, 0,0,8'h00, 8'h00};
        vecs[1]  = '{1,2,8'hA5, 0,0,8'h00, 0,0, 0,0, 0,0,1,0,0, 1,2,8'hA5, 8'h00};
        vecs[2]  = '{1,4,8'h44, 1,5,8'h55, 0,0, 0,0, 0,0,1,0,0, 1,4,8'h44, 8'h00};
        vecs[3]  = '{0,0,8'h00, 1,5,8'h55, 0,0, 0,0, 0,1,1,0,0, 1,5,8'h55, 8'h00};
        vecs[4]  = '{0,0,8'h00, 0,0,8'h00, 0,0, 0,0, 0,0,1,0,0, 0,0,8'h00, 8'h00};
        vecs[5]  = '{1,1,8'h11, 1,6,8'h66, 0,0, 0,0, 0,0,1,0,0, 1,1,8'h11, 8'h00};
        vecs[6]  = '{1,1,8'h12, 1,6,8'h66, 0,0, 0,0, 0,0,1,0,0, 1,1,8'h12, 8'h00};
        vecs[7]  = '{1,1,8'h13, 1,6,8'h66, 0,0, 0,0, 0,0,1,0,0, 1,1,8'h13, 8'h00};
        vecs[8]  = '{1,1,8'h14, 1,6,8'h66, 0,0, 0,0, 0,0,1,0,0, 1,1,8'h14, 8'h00};
        vecs[9]  = '{1,1,8'h15, 1,6,8'h66, 0,0, 0,0, 1,1,1,0,0, 1,6,8'h66, 8'h00};
        vecs[10] = '{1,1,8'h15, 1,7,8'h77, 0,0, 0,0, 0,0,1,0,0, 1,1,8'h15, 8'h00};
        vecs[11] = '{0,0,8'h00, 0,0,8'h00, 0,0, 0,0, 0,0,1,0,0, 0,0,8'h00, 8'h00};
        vecs[12] = '{0,0,8'h00, 0,0,8'h00, 1,3, 3,0, 0,0,1,0,0, 0,0,8'h00, 8'h08};
        vecs[13] = '{0,0,8'h00, 0,0,8'h00, 1,3, 3,2, 0,0,0,1,0, 0,0,8'h00, 8'h08};
        vecs[14] = '{0,0,8'h00, 1,3,8'h33, 0,0, 3,0, 0,1,1,0,0, 1,3,8'h33, 8'h00};
        vecs[15] = '{0,0,8'h00, 0,0,8'h00, 0,0, 3,0, 0,0,1,0,0, 0,0,8'h00, 8'h00};
        vecs[16] = '{1,0,8'hFF, 0,0,8'h00, 0,0, 0,0, 0,0,1,0,0, 0,0,8'h00, 8'h00};
        vecs[17] = '{0,0,8'h00, 0,0,8'h00, 1,0, 0,0, 0,0,1,0,0, 0,0,8'h00, 8'h00};
        vecs[18] = '{0,0,8'h00, 0,0,8'h00, 1,2, 0,0, 0,0,1,0,0, 0,0,8'h00, 8'h04};
        vecs[19] = '{0,0,8'h00, 1,5,8'h5A, 1,5, 0,0, 0,1,1,0,0, 1,5,8'h5A, 8'h24};
        vecs[20] = '{1,7,8'h70, 1,2,8'h22, 0,0, 2,5, 0,0,1,1,1, 1,7,8'h70, 8'h24};
        vecs[21] = '{0,0,8'h00, 1,2,8'h22, 0,0, 2,5, 0,1,1,0,1, 1,2,8'h22, 8'h20};

        driveIdle();
        rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checkVal("reset RegWrite", {7'b0, bus.RegWrite}, 8'h00);
        checkVal("reset WriteReg", {5'b0, bus.WriteReg}, 8'h00);
        checkVal("reset WriteData", bus.WriteData, 8'h00);
        checkVal("reset busy", bus.busy, 8'h00);
        checkVal("reset wb_stall", {7'b0, bus.wb_stall}, 8'h00);
        checkVal("reset mc_ready", {7'b0, bus.mc_ready}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i], i);
            checkOutput();
        end
        @(negedge clk);
        #1;
        driveIdle();
        bus.mc_valid = 1'b0;
        checkVal("rf[0]", rf[0], 8'h00);
        checkVal("rf[1]", rf[1], 8'h15);
        checkVal("rf[2]", rf[2], 8'h22);
        checkVal("rf[3]", rf[3], 8'h33);
        checkVal("rf[4]", rf[4], 8'h44);
        checkVal("rf[5]", rf[5], 8'h5A);
        checkVal("rf[6]", rf[6], 8'h66);
        checkVal("rf[7]", rf[7], 8'h70);

        // Async reset between edges while MC is pending and reservations exist.
        bus.wb_valid = 1; bus.wb_reg = 1; bus.wb_data = 8'h99;
        bus.mc_valid = 1; bus.mc_reg = 5; bus.mc_data = 8'h5B;
        bus.issue_valid = 1; bus.issue_reg = 4;
        @(posedge clk);
        #1;
        checkVal("pre-reset busy", bus.busy, 8'h30);
        checkVal("pre-reset RegWrite", {7'b0, bus.RegWrite}, 8'h01);
        checkVal("pre-reset WriteData", bus.WriteData, 8'h99);
        #2;
        rst_n = 1'b0;
        #1;
        checkVal("midreset busy", bus.busy, 8'h00);
        checkVal("midreset RegWrite", {7'b0, bus.RegWrite}, 8'h00);
        checkVal("midreset WriteData", bus.WriteData, 8'h00);
        bus.wb_valid = 0;
        bus.issue_valid = 0;
        rst_n = 1'b1;
        #1;
        checkVal("post-reset mc_ready", {7'b0, bus.mc_ready}, 8'h01);
        @(posedge clk);
        #1;
        checkVal("post-reset RegWrite", {7'b0, bus.RegWrite}, 8'h01);
        checkVal("post-reset WriteReg", {5'b0, bus.WriteReg}, 8'h05);
        checkVal("post-reset WriteData", bus.WriteData, 8'h5B);
        checkVal("post-reset busy", bus.busy, 8'h00);
        driveIdle();
        @(negedge clk);
        #1;
        checkVal("post-reset rf[5]", rf[5], 8'h5B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
